sys_bus_mem_responder: RTL and testbench
========================================

// Module: sys_bus_mem_responder
// PURPOSE
//  System-bus target model that sits downstream of the AXI3 slave bridge in the AXI-UVM bench.
//  Consumes the bridge's sys_* request strobes and returns rdata/ack/err.
//  Provides a word-addressed RAM with byte enables, programmable ack latency, and decode/alignment errors.
//  Also provides error injection, so the bridge's response mapping is exercised end to end.
// PARAMETERS
//  AXI_DW     64          data width; must be a multiple of 8
//  AXI_AW     32          address width
//  AXI_SW     AXI_DW/8    byte-select width
//  DEPTH      1024        RAM depth in AXI_DW words (power of 2)
//  BASE_ADDR  32'h4000_0000  byte address of word 0
// PORTS
//  axi_clk_i      in   1       single clock
//  axi_rst_i      in   1       synchronous reset, active-high
//  sys_addr_o     in   AXI_AW  request byte address (bridge-side name)
//  sys_wdata_o    in   AXI_DW  write data
//  sys_sel_o      in   AXI_SW  byte enables
//  sys_wen_o      in   1       write request, 1-cycle pulse
//  sys_ren_o      in   1       read request, 1-cycle pulse
//  sys_rdata_i    out  AXI_DW  read data, valid only with ack & !err
//  sys_err_i      out  1       error, qualified by ack
//  sys_ack_i      out  1       response strobe, 1-cycle pulse
//  cfg_latency_i  in   4       extra wait cycles L, sampled at accept
//  err_inject_i   in   1       force error on the request accepted this cycle
//  busy_o         out  1       transaction outstanding
//  drop_cnt_o     out  16      requests dropped while busy; saturating
// BEHAVIOUR
//  Reset: sys_ack_i, sys_err_i, busy_o = 0; sys_rdata_i = 0; drop_cnt_o = 0; FSM -> IDLE.
//    RAM contents are not reset.
//  FSM IDLE -> WAIT -> ACK -> IDLE:
//   - Accept only in IDLE when (wen|ren).
//   - At accept, latch addr, wdata, sel, op, cfg_latency_i, err_inject_i.
//  Latency: request in cycle T -> sys_ack_i high in cycle T+1+L, for exactly one cycle.
//   - L=0 goes IDLE -> ACK directly.
//  busy_o = 1 from T+1 through the ack cycle inclusive.
//   - Earliest next accept is the cycle after the ack.
//  Request while busy_o = 1: ignored; drop_cnt_o += 1, saturating at 16'hFFFF.
//  wen & ren in the same accepted cycle: treated as an error response; RAM untouched.
//  Error (sys_err_i = 1 with ack) is raised on any of:
//   - addr < BASE_ADDR
//   - addr >= BASE_ADDR + DEPTH*AXI_SW
//   - addr[$clog2(AXI_SW)-1:0] != 0
//   - latched err_inject
//   - wen & ren together
//  On an error response: sys_rdata_i = 0 and no RAM write.
//  Word index = (addr - BASE_ADDR) >> $clog2(AXI_SW), computed in AXI_AW bits; no wrap.
//  Write: commits in the ack cycle.
//   - Only lanes with sel = 1 are updated; sel = 0 gives ack with no change.
//   - A read accepted after that ack returns the new data.
//  Read: RAM read completes before ACK; sys_rdata_i carries the word in the ack cycle, 0 in all other cycles.
//  sys_err_i and sys_rdata_i are 0 whenever sys_ack_i = 0.
//  Reset mid-transaction: the pending transaction is discarded with no ack and no RAM write.
//  cfg_latency_i / err_inject_i changes after accept do not affect the transaction in flight.
// STRUCTURE
//  Package sys_bus_pkg:
//   - typedef enum {IDLE, WAIT, ACK} sys_resp_state_e
//   - typedef enum {OP_RD, OP_WR, OP_BAD} sys_op_e
//   - localparam DROP_CNT_W = 16
//  Sub-module sys_bus_byte_ram:
//   - DEPTH x AXI_DW, one port, per-byte write enable
//   - Synchronous read, 1-cycle read latency
//   - No reset
//  Top level holds the FSM, latency counter, decode/error logic and drop counter.
// TESTING
//  1. Write 0x1122334455667788 @BASE, sel=FF, L=0 -> ack at T+1, err=0.
//     Read @BASE -> ack at T+1, rdata = 0x1122334455667788.
//  2. Write 0xAAAA... @BASE+8, sel=0x0F, over 0 -> read returns 0x00000000AAAAAAAA.
//     Repeat with L=5 -> ack at T+6, busy_o high for 6 cycles.
//  3. Read @BASE+DEPTH*8 -> ack+err, rdata=0.
//     Read @BASE+4 -> ack+err.
//     Write @BASE-8 -> ack+err; a later read @BASE-8+... confirms RAM unchanged.
//  4. L=3, write @BASE; ren pulses at T+1 and T+2 -> both dropped, drop_cnt_o=2, one ack only.
//     Request in the cycle after ack -> accepted.
//  5. err_inject_i=1 with write 0xDEAD @BASE+16 -> ack+err.
//     Read @BASE+16 -> old value. wen&ren together -> ack+err.
//  6. Reset asserted at T+2 of an L=7 write -> no ack, busy_o=0, drop_cnt_o=0, RAM unchanged.
//     65537 busy drops -> drop_cnt_o = 16'hFFFF.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared types for the system-bus memory responder: FSM states, latched op kinds, drop counter width.
package sys_bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} sys_resp_state_e;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} sys_op_e;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/sys_bus_mem_responder_if.sv
// Bridge-side system bus: request strobes from the bridge, rdata/err/ack back from the target.
interface sys_bus_mem_responder_if #(
    parameter int AXI_DW = 64,
    parameter int AXI_AW = 32,
    parameter int AXI_SW = AXI_DW / 8
);
    logic [AXI_AW-1:0] sys_addr_o;
    logic [AXI_DW-1:0] sys_wdata_o;
    logic [AXI_SW-1:0] sys_sel_o;
    logic              sys_wen_o;
    logic              sys_ren_o;
    logic [AXI_DW-1:0] sys_rdata_i;
    logic              sys_err_i;
    logic              sys_ack_i;

    modport master (
        output sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o,
        input  sys_rdata_i, sys_err_i, sys_ack_i
    );

    modport slave (
        input  sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o,
        output sys_rdata_i, sys_err_i, sys_ack_i
    );
endinterface

// File: rtl/sys_bus_byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered (1-cycle) read. No reset.
module sys_bus_byte_ram #(
    parameter int DW    = 64,
    parameter int DEPTH = 1024,
    parameter int SW    = DW / 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic          we,
    input  logic [SW-1:0] be,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        q <= mem[idx];
        if (we) begin
            for (int b = 0; b < SW; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/sys_bus_mem_responder.sv
// System-bus target: byte-enabled RAM behind an IDLE/WAIT/ACK responder with programmable
// ack latency, decode/alignment error checks, error injection and a saturating drop counter.
module sys_bus_mem_responder
    import sys_bus_pkg::*;
#(
    parameter int                AXI_DW    = 64,
    parameter int                AXI_AW    = 32,
    parameter int                AXI_SW    = AXI_DW / 8,
    parameter int                DEPTH     = 1024,
    parameter logic [AXI_AW-1:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                  axi_clk_i,
    input  logic                  axi_rst_i,
    sys_bus_mem_responder_if.slave bus,
    input  logic [3:0]            cfg_latency_i,
    input  logic                  err_inject_i,
    output logic                  busy_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    localparam int OFS_W = $clog2(AXI_SW);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AXI_AW:0] BASE_X = {1'b0, BASE_ADDR};
    localparam logic [AXI_AW:0] LIMIT  = BASE_X + (AXI_AW+1)'(DEPTH * AXI_SW);

    sys_resp_state_e   state;
    sys_op_e           op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [AXI_DW-1:0] wdata_q;
    logic [AXI_SW-1:0] sel_q;
    logic              bad_q;
    logic [3:0]        cnt_q;
    logic              ack_r;
    logic              err_r;

    logic              req;
    logic              bad_in;
    logic [IDX_W-1:0]  idx_in;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic [AXI_DW-1:0] ram_q;
    sys_op_e           op_in;

    always_comb begin
        req    = bus.sys_wen_o | bus.sys_ren_o;
        // Offset is taken in AXI_AW bits; out-of-range indices are harmless since they are flagged bad.
        idx_in = IDX_W'((bus.sys_addr_o - BASE_ADDR) >> OFS_W);
        bad_in = ({1'b0, bus.sys_addr_o} < BASE_X) || ({1'b0, bus.sys_addr_o} >= LIMIT) ||
                 (bus.sys_addr_o[OFS_W-1:0] != '0) || err_inject_i ||
                 (bus.sys_wen_o && bus.sys_ren_o);
        op_in  = (bus.sys_wen_o && bus.sys_ren_o) ? OP_BAD :
                 bus.sys_wen_o ? OP_WR : OP_RD;
        // Read is launched at accept from the live address, then held on the latched index.
        ram_idx = (state == IDLE) ? idx_in : idx_q;
        ram_we  = (state == ACK) && (op_q == OP_WR) && !bad_q;
    end

    sys_bus_byte_ram #(.DW(AXI_DW), .DEPTH(DEPTH), .SW(AXI_SW), .AW(IDX_W)) u_ram (
        .clk   (axi_clk_i),
        .idx   (ram_idx),
        .we    (ram_we),
        .be    (sel_q),
        .wdata (wdata_q),
        .q     (ram_q)
    );

    assign bus.sys_ack_i   = ack_r;
    assign bus.sys_err_i   = err_r;
    assign bus.sys_rdata_i = (ack_r && !err_r && op_q == OP_RD) ? ram_q : '0;

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state      <= IDLE;
            op_q       <= OP_RD;
            idx_q      <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            bad_q      <= 1'b0;
            cnt_q      <= '0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            if (busy_o && req && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
            case (state)
                IDLE: if (req) begin
                    op_q    <= op_in;
                    idx_q   <= idx_in;
                    wdata_q <= bus.sys_wdata_o;
                    sel_q   <= bus.sys_sel_o;
                    bad_q   <= bad_in;
                    busy_o  <= 1'b1;
                    if (cfg_latency_i == 4'd0) begin
                        state <= ACK;
                        ack_r <= 1'b1;
                        err_r <= bad_in;
                    end else begin
                        state <= WAIT;
                        cnt_q <= cfg_latency_i;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state <= ACK;
                        ack_r <= 1'b1;
                        err_r <= bad_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_bus_mem_responder.sv
// Randomized self-checking bench for sys_bus_mem_responder against a word-array reference model.
module tb_sys_bus_mem_responder;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cfg_latency;
    logic        err_inject;
    logic        busy;
    logic [15:0] drop_cnt;

    int total  = 0;
    int passed = 0;
    int exp_drop = 0;
    logic [63:0] mdl [int];

    sys_bus_mem_responder_if #(.AXI_DW(64), .AXI_AW(32)) bus ();

    sys_bus_mem_responder dut (
        .axi_clk_i     (clk),
        .axi_rst_i     (rst),
        .bus           (bus),
        .cfg_latency_i (cfg_latency),
        .err_inject_i  (err_inject),
        .busy_o        (busy),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sys_addr_o  = '0;
        bus.sys_wdata_o = '0;
        bus.sys_sel_o   = '0;
        bus.sys_wen_o   = 1'b0;
        bus.sys_ren_o   = 1'b0;
        cfg_latency     = '0;
        err_inject      = 1'b0;
    endtask

    // Reference: error and read data follow directly from address arithmetic on a word array.
    task automatic model(input logic [31:0] a, input logic [63:0] wd, input logic [7:0] sel,
                         input logic we, input logic re, input logic inj,
                         output logic e, output logic [63:0] rd, output logic chk);
        longint unsigned ua;
        int idx;
        logic [63:0] w;
        ua  = a;
        e   = (ua < BASE) || (ua >= longint'(BASE) + DEPTH * 8) || (ua % 8 != 0) || inj || (we && re);
        rd  = '0;
        chk = e;
        if (!e) begin
            idx = int'((ua - BASE) / 8);
            if (we) begin
                w = mdl.exists(idx) ? mdl[idx] : 64'h0;
                for (int b = 0; b < 8; b++) if (sel[b]) w[b*8 +: 8] = wd[b*8 +: 8];
                mdl[idx] = w;
            end else if (mdl.exists(idx)) begin
                rd  = mdl[idx];
                chk = 1'b1;
            end
        end
    endtask

    // Drives one request in the current cycle and follows it to its ack.
    task automatic txn(input logic [31:0] a, input logic [63:0] wd, input logic [7:0] sel,
                       input logic we, input logic re, input logic [3:0] lat, input logic inj,
                       input string nm);
        logic e, chk;
        logic [63:0] rd;
        int n, bsy, quiet_bad;
        model(a, wd, sel, we, re, inj, e, rd, chk);
        bus.sys_addr_o = a; bus.sys_wdata_o = wd; bus.sys_sel_o = sel;
        bus.sys_wen_o = we; bus.sys_ren_o = re;
        cfg_latency = lat; err_inject = inj;
        step();
        bus.sys_wen_o = 1'b0; bus.sys_ren_o = 1'b0;
        bus.sys_addr_o = $urandom; bus.sys_wdata_o = {$urandom, $urandom};
        cfg_latency = 4'($urandom); err_inject = 1'($urandom);
        n = 1; bsy = 0; quiet_bad = 0;
        while (!bus.sys_ack_i && n < 40) begin
            if (busy) bsy++;
            if (bus.sys_err_i || bus.sys_rdata_i != '0) quiet_bad++;
            step();
            n++;
        end
        if (busy) bsy++;
        total++;
        if (n !== 1 + int'(lat)) $display("FAIL %s latency got %0d want %0d", nm, n, 1 + int'(lat));
        else passed++;
        total++;
        if (bus.sys_err_i !== e) $display("FAIL %s err got %0b want %0b", nm, bus.sys_err_i, e);
        else passed++;
        if (chk) begin
            total++;
            if (bus.sys_rdata_i !== rd) $display("FAIL %s rdata got %h want %h", nm, bus.sys_rdata_i, rd);
            else passed++;
        end
        total++;
        if (bsy !== 1 + int'(lat) || quiet_bad != 0)
            $display("FAIL %s busy cycles got %0d want %0d (quiet violations %0d)", nm, bsy, 1 + int'(lat), quiet_bad);
        else passed++;
        step();
        total++;
        if (bus.sys_ack_i !== 1'b0 || bus.sys_err_i !== 1'b0 || busy !== 1'b0 || bus.sys_rdata_i !== '0)
            $display("FAIL %s post-ack ack=%0b err=%0b busy=%0b rdata=%h want all 0", nm,
                     bus.sys_ack_i, bus.sys_err_i, busy, bus.sys_rdata_i);
        else passed++;
        cfg_latency = '0; err_inject = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        exp_drop = 0;
        step();
        total++;
        if ({bus.sys_ack_i, bus.sys_err_i, busy} !== 3'b000 || bus.sys_rdata_i !== '0 || drop_cnt !== 16'h0)
            $display("FAIL reset ack=%0b err=%0b busy=%0b rdata=%h drop=%0d want all 0",
                     bus.sys_ack_i, bus.sys_err_i, busy, bus.sys_rdata_i, drop_cnt);
        else passed++;
    endtask

    task automatic test_basic();
        txn(BASE, 64'h1122334455667788, 8'hFF, 1, 0, 0, 0, "wr_base");
        txn(BASE, 64'h0, 8'h00, 0, 1, 0, 0, "rd_base");
    endtask

    task automatic test_partial_latency();
        txn(BASE + 8, 64'h0, 8'hFF, 1, 0, 0, 0, "clr_w1");
        txn(BASE + 8, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1, 0, 0, 0, "part_w1");
        txn(BASE + 8, 64'h0, 8'h00, 0, 1, 0, 0, "rd_part_w1");
        txn(BASE + 8, 64'h5555555555555555, 8'hF0, 1, 0, 5, 0, "part_w1_l5");
        txn(BASE + 8, 64'h0, 8'h00, 0, 1, 5, 0, "rd_w1_l5");
        txn(BASE + 8, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1, 0, 2, 0, "sel0_w1");
        txn(BASE + 8, 64'h0, 8'h00, 0, 1, 0, 0, "rd_sel0_w1");
    endtask

    task automatic test_errors();
        txn(BASE + DEPTH * 8, 64'h0, 8'h00, 0, 1, 0, 0, "rd_past_end");
        txn(BASE + 4, 64'h0, 8'h00, 0, 1, 1, 0, "rd_misalign");
        txn(BASE + (DEPTH - 1) * 8, 64'hC0FFEE00C0FFEE00, 8'hFF, 1, 0, 0, 0, "wr_last");
        txn(BASE - 8, 64'h0123456789ABCDEF, 8'hFF, 1, 0, 0, 0, "wr_below_base");
        txn(BASE + (DEPTH - 1) * 8, 64'h0, 8'h00, 0, 1, 0, 0, "rd_last_unchanged");
    endtask

    task automatic test_drops();
        logic e, chk;
        logic [63:0] rd;
        int acks, at;
        model(BASE, 64'h0BADF00D12345678, 8'hFF, 1, 0, 0, e, rd, chk);
        bus.sys_addr_o = BASE; bus.sys_wdata_o = 64'h0BADF00D12345678; bus.sys_sel_o = 8'hFF;
        bus.sys_wen_o = 1'b1; cfg_latency = 4'd3;
        step();
        bus.sys_wen_o = 1'b0; cfg_latency = 4'd0;
        acks = 0; at = 0;
        for (int n = 1; n <= 4; n++) begin
            if (bus.sys_ack_i) begin acks++; at = n; end
            bus.sys_ren_o = (n == 1 || n == 2);
            step();
        end
        exp_drop += 2;
        total++;
        if (acks !== 1 || at !== 4) $display("FAIL drop_acks got %0d at %0d want 1 at 4", acks, at);
        else passed++;
        total++;
        if (drop_cnt !== 16'(exp_drop)) $display("FAIL drop_cnt got %0d want %0d", drop_cnt, exp_drop);
        else passed++;
        txn(BASE, 64'h0, 8'h00, 0, 1, 0, 0, "rd_after_ack");
    endtask

    task automatic test_inject();
        txn(BASE + 16, 64'h7777666655554444, 8'hFF, 1, 0, 0, 0, "wr_w2");
        txn(BASE + 16, 64'hDEAD, 8'hFF, 1, 0, 2, 1, "inj_wr_w2");
        txn(BASE + 16, 64'h0, 8'h00, 0, 1, 0, 0, "rd_w2_old");
        txn(BASE + 16, 64'hDEAD, 8'hFF, 1, 1, 0, 0, "wen_ren_w2");
        txn(BASE + 16, 64'h0, 8'h00, 0, 1, 3, 0, "rd_w2_still_old");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic we, re;
        int k, r;
        for (int w = 0; w < 8; w++)
            txn(BASE + 32'(w * 8), {$urandom, $urandom}, 8'hFF, 1, 0, 4'($urandom_range(0, 2)), 0, "rnd_init");
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 8) a = BASE + 32'(k * 8);
            else if (k == 8) a = BASE + 32'($urandom_range(0, 7) * 8 + $urandom_range(1, 7));
            else a = BASE + DEPTH * 8 + 32'($urandom_range(0, 15) * 8);
            r = $urandom_range(0, 9);
            we = (r < 4) || (r == 9);
            re = (r >= 4);
            txn(a, {$urandom, $urandom}, 8'($urandom), we, re, 4'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0), "rnd");
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        txn(BASE + 24, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 1, 0, 0, 0, "wr_w3");
        bus.sys_addr_o = BASE + 24; bus.sys_wdata_o = 64'hFFFF0000FFFF0000; bus.sys_sel_o = 8'hFF;
        bus.sys_wen_o = 1'b1; cfg_latency = 4'd7;
        step();
        bus.sys_wen_o = 1'b0; bus.sys_ren_o = 1'b1;
        step();
        bus.sys_ren_o = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; cfg_latency = 4'd0;
        exp_drop = 0;
        total++;
        if (busy !== 1'b0 || drop_cnt !== 16'(exp_drop) || bus.sys_ack_i !== 1'b0)
            $display("FAIL mid_reset busy=%0b drop=%0d ack=%0b want 0 0 0", busy, drop_cnt, bus.sys_ack_i);
        else passed++;
        acks = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.sys_ack_i || busy) acks++;
            step();
        end
        total++;
        if (acks !== 0) $display("FAIL mid_reset_quiet got %0d active cycles want 0", acks);
        else passed++;
        txn(BASE + 24, 64'h0, 8'h00, 0, 1, 0, 0, "rd_w3_unchanged");
    endtask

    task automatic test_saturate();
        int guard;
        logic mid_done;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_drop = 0;
        guard = 0; mid_done = 1'b0;
        bus.sys_addr_o = BASE; bus.sys_ren_o = 1'b1; cfg_latency = 4'd15;
        while (exp_drop < 65537 && guard < 80000) begin
            if (exp_drop == 1000 && !mid_done) begin
                mid_done = 1'b1;
                total++;
                if (drop_cnt !== 16'(exp_drop)) $display("FAIL drop_mid got %0d want %0d", drop_cnt, exp_drop);
                else passed++;
            end
            if (busy) exp_drop++;
            step();
            guard++;
        end
        bus.sys_ren_o = 1'b0; cfg_latency = 4'd0;
        total++;
        if (drop_cnt !== 16'hFFFF || exp_drop < 65537)
            $display("FAIL drop_sat got %h want ffff (drops issued %0d)", drop_cnt, exp_drop);
        else passed++;
        guard = 0;
        while (busy && guard < 20) begin step(); guard++; end
        total++;
        if (busy !== 1'b0) $display("FAIL sat_drain busy got %0b want 0", busy);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_partial_latency();
        test_errors();
        test_drops();
        test_inject();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
